hopfield_engine: RTL

Parametrised, self-sequencing Hopfield associative-memory engine. It is the successor to the fixed-size Hopfield datapath: neuron count and weight width are parameters, and the external modify/learn strobing is replaced by a command handshake. Three commands are supported: clear weights, Hebbian learn, and iterative recall. Recall has hardware convergence detection, a sweep counter and an iteration-limit timeout. The block sits under the top-level controller, which issues commands and reads back the recalled pattern.

---
 rtl/hopfield_engine.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hopfield_engine.sv
// Parametrised Hopfield associative memory: clears, learns (Hebbian, saturating)
// and recalls patterns through a single-command handshake, one neuron row per cycle.
module hopfield_engine #(
    parameter int N        = 16,
    parameter int WW       = 4,
    parameter int MAX_ITER = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [N-1:0]                    pattern_in,
    output logic [N-1:0]                    neuron_states,
    output logic                            same_input,
    output logic                            done,
    output logic                            converged,
    output logic                            timeout,
    output logic [$clog2(MAX_ITER+1)-1:0]   sweeps
);

    localparam int KW = $clog2(N);
    localparam int AW = WW + $clog2(N);
    localparam int SW = $clog2(MAX_ITER + 1);

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_LEARN  = 2'b01;
    localparam logic [1:0] OP_RECALL = 2'b10;

    localparam logic signed [WW-1:0] W_MAX = WW'(2 ** (WW - 1) - 1);
    localparam logic signed [WW-1:0] W_MIN = -W_MAX;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEARN,
        RECALL,
        NOP
    } state_t;

    state_t state, next_state;

    logic signed [WW-1:0] w [N][N];

    logic [KW-1:0]  k;
    logic [N-1:0]   last_pattern;
    logic           last_valid;
    logic           change_flag;

    logic           accept;
    logic           last_row;
    logic           finish;
    logic signed [AW-1:0] h;
    logic           new_bit;
    logic           change_now;
    logic [SW-1:0]  sweep_next;

    // Saturating +/-1 step that keeps weights inside the symmetric legal range.
    function automatic logic signed [WW-1:0] sat_step(input logic signed [WW-1:0] v,
                                                      input logic up);
        if (up)
            return (v == W_MAX) ? v : v + WW'(1);
        else
            return (v == W_MIN) ? v : v - WW'(1);
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign last_row   = (k == KW'(N - 1));
    assign same_input = last_valid && (pattern_in == last_pattern);
    assign sweep_next = sweeps + SW'(1);

    // Local field of neuron k; the accumulator is wide enough that it cannot overflow.
    always_comb begin
        h = '0;
        for (int j = 0; j < N; j++) begin
            logic signed [AW-1:0] term;
            term = w[k][j];
            if (j != int'(k)) begin
                if (neuron_states[j])
                    h = h + term;
                else
                    h = h - term;
            end
        end
    end

    always_comb begin
        new_bit = neuron_states[k];
        if (h > 0)
            new_bit = 1'b1;
        else if (h < 0)
            new_bit = 1'b0;
        change_now = change_flag || (new_bit != neuron_states[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_CLEAR:  next_state = CLEAR;
                        OP_LEARN:  next_state = LEARN;
                        OP_RECALL: next_state = RECALL;
                        default:   next_state = NOP;
                    endcase
                end
            end
            CLEAR, LEARN: begin
                if (last_row)
                    next_state = IDLE;
            end
            RECALL: begin
                if (last_row && (!change_now || sweep_next == SW'(MAX_ITER)))
                    next_state = IDLE;
            end
            NOP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign finish = (state != IDLE) && (next_state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k             <= '0;
            neuron_states <= '0;
            last_pattern  <= '0;
            last_valid    <= 1'b0;
            change_flag   <= 1'b0;
            sweeps        <= '0;
            converged     <= 1'b0;
            timeout       <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                k           <= '0;
                change_flag <= 1'b0;
                converged   <= 1'b0;
                timeout     <= 1'b0;
                sweeps      <= '0;
                if (cmd_op == OP_LEARN || cmd_op == OP_RECALL) begin
                    last_pattern <= pattern_in;
                    last_valid   <= 1'b1;
                end
                if (cmd_op == OP_RECALL)
                    neuron_states <= pattern_in;
            end else begin
                case (state)
                    CLEAR, LEARN: k <= last_row ? '0 : k + KW'(1);
                    RECALL: begin
                        neuron_states[k] <= new_bit;
                        if (last_row) begin
                            sweeps      <= sweep_next;
                            k           <= '0;
                            change_flag <= 1'b0;
                            if (!change_now)
                                converged <= 1'b1;
                            else if (sweep_next == SW'(MAX_ITER))
                                timeout <= 1'b1;
                        end else begin
                            k           <= k + KW'(1);
                            change_flag <= change_now;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // LEARN touches row k and column k together so the array stays symmetric;
    // the diagonal is never written outside reset/clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w[i][j] <= '0;
        end else if (state == CLEAR) begin
            for (int j = 0; j < N; j++)
                w[k][j] <= '0;
        end else if (state == LEARN) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (i != j && (i == int'(k) || j == int'(k)))
                        w[i][j] <= sat_step(w[i][j], last_pattern[i] == last_pattern[j]);
        end
    end

    a_exclusive_status: assert property (@(posedge clk) disable iff (!rst)
        !(converged && timeout));

endmodule
